// File: rtl/nv_nvdla_cdma_wt_rd_sched.sv
// rtl/nv_nvdla_cdma_wt_rd_sched.sv - CDMA weight-fetch read-request scheduler (fixed priority + burst lock)
// Optional anti-starvation counter for req1: define NVDLA_CDMA_WT_SCHED_STARVE_EN.
module nv_nvdla_cdma_wt_rd_sched #(
    parameter int PW         = 79,
    parameter int STARVE_MAX = 4,
    parameter int BEAT_CW    = 8
) (
    input  logic               nvdla_core_clk,
    input  logic               nvdla_core_rstn,
    input  logic               req0_valid,
    output logic               req0_ready,
    input  logic [PW-1:0]      req0_pd,
    input  logic               req0_last,
    input  logic               req1_valid,
    output logic               req1_ready,
    input  logic [PW-1:0]      req1_pd,
    input  logic               req1_last,
    input  logic               gnt_busy,
    output logic               dma_valid,
    input  logic               dma_ready,
    output logic [PW-1:0]      dma_pd,
    output logic               dma_last,
    output logic               dma_src,
    output logic               sched_idle,
    output logic [BEAT_CW-1:0] beat_cnt
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_lock_owner;
    logic [BEAT_CW-1:0] r_beat_cnt;
    logic               r_cnt_clr;
    logic               w_sel;
    logic               w_sel_act;
    logic               w_sel_valid;
    logic               w_accept;
    logic               w_starve_hit;

`ifdef NVDLA_CDMA_WT_SCHED_STARVE_EN
    logic [3:0] r_starve_cnt;

    // req1 is forced through once req0 has won STARVE_MAX bursts in a row over it
    assign w_starve_hit = (r_starve_cnt == 4'(STARVE_MAX)) && req1_valid;

    // Count consecutive req0 burst wins while req1 waits; saturating
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            r_starve_cnt <= 4'd0;
        end else if ((r_state == ST_IDLE) && w_accept) begin
            if (w_sel || !req1_valid) begin
                r_starve_cnt <= 4'd0;
            end else if (r_starve_cnt != 4'(STARVE_MAX)) begin
                r_starve_cnt <= r_starve_cnt + 4'd1;
            end
        end
    end
`else
    logic w_unused_starve_max;
    assign w_unused_starve_max = |4'(STARVE_MAX);
    assign w_starve_hit        = 1'b0;
`endif

    // Selection: held owner while locked, otherwise priority arbitration unless busy
    always_comb begin
        w_sel       = 1'b0;
        w_sel_act   = 1'b0;
        w_sel_valid = 1'b0;
        if (r_state == ST_LOCK) begin
            w_sel       = r_lock_owner;
            w_sel_act   = 1'b1;
            w_sel_valid = r_lock_owner ? req1_valid : req0_valid;
        end else if (!gnt_busy) begin
            if (w_starve_hit) begin
                w_sel       = 1'b1;
                w_sel_act   = 1'b1;
                w_sel_valid = 1'b1;
            end else if (req0_valid) begin
                w_sel_act   = 1'b1;
                w_sel_valid = 1'b1;
            end else if (req1_valid) begin
                w_sel       = 1'b1;
                w_sel_act   = 1'b1;
                w_sel_valid = 1'b1;
            end
        end
    end

    assign dma_valid  = w_sel_valid;
    assign dma_pd     = w_sel ? req1_pd : req0_pd;
    assign dma_last   = w_sel ? req1_last : req0_last;
    assign dma_src    = w_sel;
    assign req0_ready = w_sel_act && !w_sel && dma_ready;
    assign req1_ready = w_sel_act && w_sel && dma_ready;
    assign w_accept   = w_sel_valid && dma_ready;
    assign sched_idle = (r_state == ST_IDLE) && !w_sel_valid;
    assign beat_cnt   = r_beat_cnt;

    // Next state: lock on a non-final first beat, release on the accepted last beat
    always_comb begin
        w_state_nxt = r_state;
        if (w_accept) begin
            if (r_state == ST_IDLE && !dma_last) begin
                w_state_nxt = ST_LOCK;
            end else if (r_state == ST_LOCK && dma_last) begin
                w_state_nxt = ST_IDLE;
            end
        end
    end

    // State and lock owner registers
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            r_state      <= ST_IDLE;
            r_lock_owner <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_IDLE && w_accept && !dma_last) begin
                r_lock_owner <= w_sel;
            end
        end
    end

    // Beat counter: the final count stays visible one cycle, then clears
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            r_beat_cnt <= '0;
            r_cnt_clr  <= 1'b0;
        end else begin
            r_cnt_clr <= w_accept && dma_last;
            if (w_accept) begin
                r_beat_cnt <= (r_cnt_clr ? '0 : r_beat_cnt) + 1'b1;
            end else if (r_cnt_clr) begin
                r_beat_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_nv_nvdla_cdma_wt_rd_sched.sv
// tb/tb_nv_nvdla_cdma_wt_rd_sched.sv - directed scoreboard bench for nv_nvdla_cdma_wt_rd_sched
module tb_nv_nvdla_cdma_wt_rd_sched;

    localparam int PW      = 79;
    localparam int BEAT_CW = 8;

    typedef struct {
        logic          src;
        logic [PW-1:0] pd;
        logic          last;
    } beat_t;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               req0_valid, req0_ready, req0_last;
    logic               req1_valid, req1_ready, req1_last;
    logic [PW-1:0]      req0_pd, req1_pd, dma_pd;
    logic               gnt_busy, dma_valid, dma_ready, dma_last, dma_src, sched_idle;
    logic [BEAT_CW-1:0] beat_cnt;

    int    n_checks = 0;
    int    n_errors = 0;
    beat_t exp_q[$];

    always #5 clk = ~clk;

    nv_nvdla_cdma_wt_rd_sched #(.PW(PW), .STARVE_MAX(4), .BEAT_CW(BEAT_CW)) dut (
        .nvdla_core_clk (clk),
        .nvdla_core_rstn(rst_n),
        .req0_valid     (req0_valid),
        .req0_ready     (req0_ready),
        .req0_pd        (req0_pd),
        .req0_last      (req0_last),
        .req1_valid     (req1_valid),
        .req1_ready     (req1_ready),
        .req1_pd        (req1_pd),
        .req1_last      (req1_last),
        .gnt_busy       (gnt_busy),
        .dma_valid      (dma_valid),
        .dma_ready      (dma_ready),
        .dma_pd         (dma_pd),
        .dma_last       (dma_last),
        .dma_src        (dma_src),
        .sched_idle     (sched_idle),
        .beat_cnt       (beat_cnt)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic s, input logic [PW-1:0] p, input logic l);
        beat_t b;
        b.src  = s;
        b.pd   = p;
        b.last = l;
        exp_q.push_back(b);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Compare every accepted beat against the oldest expected beat
    always @(negedge clk) begin
        if (rst_n && dma_valid && dma_ready) begin
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_beat", 1, 0);
            end else begin
                beat_t e;
                e = exp_q.pop_front();
                chk("sb_src", dma_src, e.src);
                chk("sb_pd", dma_pd, e.pd);
                chk("sb_last", dma_last, e.last);
            end
        end
    end

    initial begin
        logic exp_src;
        rst_n = 1'b0;
        req0_valid = 0; req0_last = 0; req0_pd = '0;
        req1_valid = 0; req1_last = 0; req1_pd = '0;
        gnt_busy = 0; dma_ready = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // reset state holds with idle inputs
        for (int i = 0; i < 3; i++) begin
            #2;
            chk("rst_dma_valid", dma_valid, 0);
            chk("rst_sched_idle", sched_idle, 1);
            chk("rst_beat_cnt", beat_cnt, 0);
            chk("rst_readies", {req0_ready, req1_ready}, 0);
            chk("rst_dma_src", dma_src, 0);
            tick();
        end

        // req0 3-beat burst with req1 pending
        dma_ready = 1; req1_valid = 1; req1_last = 1; req1_pd = PW'(32'h200);
        for (int b = 1; b <= 3; b++) begin
            req0_valid = 1; req0_pd = PW'(32'h100 + b); req0_last = (b == 3);
            push(0, PW'(32'h100 + b), b == 3);
            #2;
            chk("burst_src0", dma_src, 0);
            chk("burst_req1_ready", req1_ready, 0);
            chk("burst_req0_ready", req0_ready, 1);
            tick();
            chk("burst_beat_cnt", beat_cnt, b);
        end
        req0_valid = 0;
        push(1, PW'(32'h200), 1);
        #2;
        chk("after_burst_src1", dma_src, 1);
        chk("after_burst_req1_ready", req1_ready, 1);
        tick();
        chk("cnt_after_clear", beat_cnt, 1);
        req1_valid = 0;
        tick();
        chk("cnt_cleared", beat_cnt, 0);

        // bubble inside a locked req0 burst: no switch to req1
        req1_valid = 1; req1_last = 1; req1_pd = PW'(32'h300);
        for (int b = 1; b <= 4; b++) begin
            if (b == 3) begin
                req0_valid = 0;
                for (int k = 0; k < 2; k++) begin
                    #2;
                    chk("bubble_dma_valid", dma_valid, 0);
                    chk("bubble_req1_ready", req1_ready, 0);
                    chk("bubble_sched_idle", sched_idle, 0);
                    tick();
                    chk("bubble_beat_cnt", beat_cnt, 2);
                end
            end
            req0_valid = 1; req0_pd = PW'(32'h400 + b); req0_last = (b == 4);
            push(0, PW'(32'h400 + b), b == 4);
            #2;
            chk("lock_src0", dma_src, 0);
            tick();
            chk("lock_beat_cnt", beat_cnt, b);
        end
        req0_valid = 0;
        push(1, PW'(32'h300), 1);
        #2;
        chk("post_lock_src1", dma_src, 1);
        tick();
        req1_valid = 0;
        tick();

        // gnt_busy in IDLE blocks arbitration
        gnt_busy = 1; req0_valid = 1; req0_last = 1; req1_valid = 1; req1_last = 1;
        for (int k = 0; k < 2; k++) begin
            #2;
            chk("busy_dma_valid", dma_valid, 0);
            chk("busy_readies", {req0_ready, req1_ready}, 0);
            chk("busy_sched_idle", sched_idle, 1);
            tick();
            chk("busy_beat_cnt", beat_cnt, 0);
        end
        // gnt_busy during LOCK does not stop the owner
        gnt_busy = 0; req1_valid = 0;
        req0_pd = PW'(32'h801); req0_last = 0;
        push(0, PW'(32'h801), 0);
        #2;
        chk("busy_lock_first", dma_valid, 1);
        tick();
        gnt_busy = 1;
        req0_pd = PW'(32'h802); req0_last = 1;
        push(0, PW'(32'h802), 1);
        #2;
        chk("busy_lock_valid", dma_valid, 1);
        chk("busy_lock_ready", req0_ready, 1);
        tick();
        chk("busy_lock_cnt", beat_cnt, 2);
        gnt_busy = 0; req0_valid = 0;
        tick();

        // back-to-back single-beat req0 bursts with req1 always waiting
        for (int i = 0; i < 10; i++) begin
            req0_valid = 1; req0_last = 1; req0_pd = PW'(32'h500 + i);
            req1_valid = 1; req1_last = 1; req1_pd = PW'(32'h600 + i);
`ifdef NVDLA_CDMA_WT_SCHED_STARVE_EN
            exp_src = ((i % 5) == 4);
`else
            exp_src = 1'b0;
`endif
            push(exp_src, exp_src ? PW'(32'h600 + i) : PW'(32'h500 + i), 1);
            #2;
            chk("starve_src", dma_src, exp_src);
            tick();
        end
        req0_valid = 0; req1_valid = 0;
        tick();

        // async reset in the middle of a locked burst
        req0_valid = 1;
        for (int b = 1; b <= 2; b++) begin
            req0_pd = PW'(32'h900 + b); req0_last = 0;
            push(0, PW'(32'h900 + b), 0);
            tick();
        end
        chk("pre_reset_cnt", beat_cnt, 2);
        rst_n = 0; req0_valid = 0;
        #1;
        chk("reset_beat_cnt", beat_cnt, 0);
        chk("reset_sched_idle", sched_idle, 1);
        chk("reset_dma_valid", dma_valid, 0);
        tick();
        rst_n = 1;
        req1_valid = 1; req1_last = 1; req1_pd = PW'(32'h700);
        push(1, PW'(32'h700), 1);
        #2;
        chk("post_reset_valid", dma_valid, 1);
        chk("post_reset_src", dma_src, 1);
        chk("post_reset_req1_ready", req1_ready, 1);
        tick();
        chk("post_reset_cnt", beat_cnt, 1);
        req1_valid = 0;
        tick();
        chk("sb_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/nv_nvdla_cdma_wt_rd_sched.md
Name: nv_nvdla_cdma_wt_rd_sched

Overview:
Schedules two CDMA weight-fetch requesters onto the single DMA read-request channel. Requester 0 is the weight fetch and requester 1 is the WMB (weight-mask) fetch. Uses fixed priority with req0 highest, plus burst locking: once a requester wins, it owns the channel until its last beat is accepted. An external busy input freezes new arbitration. An optional anti-starvation counter guarantees req1 progress.

Parameters:
PW, 79, request payload width (addr+size), passed through unmodified
STARVE_MAX, 4, consecutive req0 burst wins tolerated while req1 waits (legal 1..15)
BEAT_CW, 8, width of the per-burst beat counter

Ports:
nvdla_core_clk  input  1  core clock
nvdla_core_rstn  input  1  asynchronous active-low reset
req0_valid  input  1  requester 0 beat valid
req0_ready  output  1  requester 0 beat accepted
req0_pd  input  PW  requester 0 payload
req0_last  input  1  final beat of the req0 burst
req1_valid  input  1  requester 1 beat valid
req1_ready  output  1  requester 1 beat accepted
req1_pd  input  PW  requester 1 payload
req1_last  input  1  final beat of the req1 burst
gnt_busy  input  1  blocks new arbitration (does not affect a held lock)
dma_valid  output  1  beat to the DMA request channel
dma_ready  input  1  DMA accepts the beat
dma_pd  output  PW  muxed payload
dma_last  output  1  muxed last flag
dma_src  output  1  source of the current dma beat (0 or 1)
sched_idle  output  1  FSM in IDLE and no valid beat presented
beat_cnt  output  BEAT_CW  beats accepted in the current burst

Behaviour:
- State register has two states, IDLE and LOCK. A lock_owner register (1b) records the winner.
- Reset (async, rstn low): state=IDLE, lock_owner=0, beat_cnt=0, starve_cnt=0. With inputs idle, outputs then read dma_valid=0, req*_ready=0, dma_src=0, sched_idle=1.
- IDLE arbitration is combinational, with zero-cycle latency from req valid to dma_valid:
  - gnt_busy=1 -> no grant; dma_valid=0; both readies 0.
  - Otherwise req0_valid -> select 0; else req1_valid -> select 1; else none.
  - Starvation override (feature on): starve_cnt==STARVE_MAX and req1_valid -> select 1, even if req0_valid.
- LOCK: the selection is lock_owner, regardless of the other valid or gnt_busy.
- Mux outputs: dma_valid = sel_valid; dma_pd/dma_last/dma_src come from the selected requester. The selected requester's ready = dma_ready; the non-selected ready is 0.
- A beat is accepted when dma_valid & dma_ready.
- Transitions:
  - IDLE, accept, last=0 -> LOCK, lock_owner<=sel.
  - IDLE, accept, last=1 -> stay IDLE (single-beat burst).
  - LOCK, accept, last=1 -> IDLE.
  - LOCK, owner valid drops -> stay LOCK with dma_valid=0 (bubble allowed, no re-arbitration).
- beat_cnt: +1 on each accepted beat; cleared to 0 on the cycle after an accepted last beat. Wraps modulo 2^BEAT_CW with no error flag.
- Payload is never registered: dma_pd follows the selected req_pd each cycle.
- Simultaneous gnt_busy rising with an IDLE accept in the same cycle: gnt_busy wins, so no accept occurs.
- Reset asserted mid-burst: lock dropped immediately, no recovery. Requesters are reset in the same domain.

Optional Feature:
Macro NVDLA_CDMA_WT_SCHED_STARVE_EN.
- Defined: 4-bit starve_cnt.
  - Increments when an IDLE arbitration grants req0 while req1_valid=1.
  - Clears when req1 is granted, or when an arbitration happens with req1_valid=0.
  - Saturates at STARVE_MAX.
  - At STARVE_MAX, the next IDLE arbitration with req1_valid=1 grants req1.
- Undefined: starve_cnt does not exist; pure fixed priority; req1 can starve indefinitely.

Test Plan:
- Reset with all valids=0 -> dma_valid=0, sched_idle=1, beat_cnt=0, readies 0; hold 3 cycles unchanged.
- req0 3-beat burst and req1 valid at the same time, dma_ready=1 -> dma_src=0 for 3 beats, req1_ready=0 throughout; req1 granted on cycle 4; beat_cnt reads 1,2,3 then resets.
- req0 burst mid-way (beat 2 of 4), req0_valid low 2 cycles while req1_valid=1 -> dma_valid=0 for 2 cycles, no switch to req1; resumes with req0 beats 3,4.
- gnt_busy=1 while IDLE with both valid -> no accept. gnt_busy=1 asserted during LOCK -> owner beats continue to completion.
- STARVE_EN, STARVE_MAX=4, req0 issues back-to-back single-beat bursts with req1 always valid -> grant pattern 0,0,0,0,1,0,0,0,0,1. Without macro -> all grants 0.
- Async reset pulse while in LOCK at beat 2 -> state=IDLE, beat_cnt=0 immediately. After release, req1-only valid -> granted at once.
